// File: rtl/exec_control.sv
// exec_control: two-state issue/writeback controller in front of the combinational ALU.
// Owns an 8-entry register file (R0 hard-wired to zero), the stored C/S/O/Z flags
// and the program counter. One instruction completes every two cycles:
// an accept edge in IDLE, then an execute edge in EXEC.
module exec_control #(
   parameter int BITS_DATA = 32,
   parameter int BITS_PC   = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [31:0]          instr,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   output logic [4:0]           alu_opcode,
   output logic [BITS_DATA-1:0] alu_a,
   output logic [BITS_DATA-1:0] alu_b,
   input  logic [BITS_DATA-1:0] alu_resultado,
   input  logic                 alu_C,
   input  logic                 alu_S,
   input  logic                 alu_O,
   input  logic                 alu_Z,
   output logic [3:0]           flags,
   output logic [BITS_PC-1:0]   pc,
   output logic                 halted,
   output logic                 illegal,
   input  logic [2:0]           dbg_addr,
   output logic [BITS_DATA-1:0] dbg_data
);

   // Opcode encoding shared with the ALU.
   localparam logic [4:0] OP_NOP = 5'd0;
   localparam logic [4:0] OP_NOT = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4;
   localparam logic [4:0] OP_NEG = 5'd5;
   localparam logic [4:0] OP_ADD = 5'd6;
   localparam logic [4:0] OP_SUB = 5'd7;
   localparam logic [4:0] OP_MUL = 5'd8;
   localparam logic [4:0] OP_DIV = 5'd9;
   localparam logic [4:0] OP_MOD = 5'd10;
   localparam logic [4:0] OP_LD  = 5'd11;
   localparam logic [4:0] OP_STR = 5'd12;
   localparam logic [4:0] OP_JMP = 5'd13;
   localparam logic [4:0] OP_JC  = 5'd14;
   localparam logic [4:0] OP_JS  = 5'd15;
   localparam logic [4:0] OP_JO  = 5'd16;
   localparam logic [4:0] OP_JZ  = 5'd17;
   localparam logic [4:0] OP_HLT = 5'd18;

   localparam logic [BITS_DATA-1:0] DATA_ZERO = {BITS_DATA{1'b0}};
   localparam logic [BITS_PC-1:0]   PC_ZERO   = {BITS_PC{1'b0}};
   localparam logic [BITS_PC-1:0]   PC_ONE    = {{(BITS_PC-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Opcodes outside the supported set execute as NOP and raise illegal.
   function automatic logic is_illegal(input logic [4:0] op);
      logic ill;
      case (op)
         OP_NOP, OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB,
         OP_LD, OP_JMP, OP_JC, OP_JS, OP_JO, OP_JZ, OP_HLT: ill = 1'b0;
         default:                                           ill = 1'b1;
      endcase
      return ill;
   endfunction

   state_t                 state_r;
   state_t                 state_s;
   logic [31:0]            ir_r;
   logic [BITS_DATA-1:0]   regs_r [8];
   logic [3:0]             flags_r;
   logic [BITS_PC-1:0]     pc_r;
   logic                   ready_r;
   logic                   halted_r;
   logic                   illegal_r;
   logic [4:0]             alu_opcode_r;

   logic [4:0]             op_s;
   logic [2:0]             rd_s;
   logic [2:0]             ra_s;
   logic [2:0]             rb_s;
   logic [17:0]            imm_s;
   logic [BITS_PC-1:0]     target_s;
   logic                   accept_s;
   logic                   wr_en_s;
   logic [BITS_DATA-1:0]   wr_data_s;
   logic                   flags_we_s;
   logic [BITS_PC-1:0]     pc_s;

   assign op_s     = ir_r[31:27];
   assign rd_s     = ir_r[26:24];
   assign ra_s     = ir_r[23:21];
   assign rb_s     = ir_r[20:18];
   assign imm_s    = ir_r[17:0];
   assign target_s = imm_s[BITS_PC-1:0];

   assign instr_ready = ready_r;
   assign halted      = halted_r;
   assign illegal     = illegal_r;
   assign alu_opcode  = alu_opcode_r;
   assign flags       = flags_r;
   assign pc          = pc_r;

   // Combinational register-file read ports; R0 always reads as zero.
   always_comb begin
      alu_a    = (ra_s == 3'd0)     ? DATA_ZERO : regs_r[ra_s];
      alu_b    = (rb_s == 3'd0)     ? DATA_ZERO : regs_r[rb_s];
      dbg_data = (dbg_addr == 3'd0) ? DATA_ZERO : regs_r[dbg_addr];
   end

   // Next-state logic: accept in IDLE, execute once, park forever in HALT.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (instr_valid) begin
               state_s  = ST_EXEC;
               accept_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (op_s == OP_HLT) begin
               state_s = ST_HALT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HALT: state_s = ST_HALT;
         default: state_s = ST_IDLE;
      endcase
   end

   // Execute decode: writeback data, flag update enable and next pc for ir.
   always_comb begin
      wr_en_s    = 1'b0;
      wr_data_s  = DATA_ZERO;
      flags_we_s = 1'b0;
      pc_s       = pc_r + PC_ONE;
      case (op_s)
         OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB: begin
            wr_en_s    = 1'b1;
            wr_data_s  = alu_resultado;
            flags_we_s = 1'b1;
         end
         OP_LD: begin
            wr_en_s   = 1'b1;
            wr_data_s = {{(BITS_DATA-18){1'b0}}, imm_s};
         end
         OP_JMP: pc_s = target_s;
         OP_JC: begin
            if (flags_r[3]) pc_s = target_s; else pc_s = pc_r + PC_ONE;
         end
         OP_JS: begin
            if (flags_r[2]) pc_s = target_s; else pc_s = pc_r + PC_ONE;
         end
         OP_JO: begin
            if (flags_r[1]) pc_s = target_s; else pc_s = pc_r + PC_ONE;
         end
         OP_JZ: begin
            if (flags_r[0]) pc_s = target_s; else pc_s = pc_r + PC_ONE;
         end
         OP_HLT:  pc_s = pc_r;
         default: pc_s = pc_r + PC_ONE;
      endcase
   end

   // State register and registered, state-derived handshake/status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         ready_r      <= 1'b1;
         halted_r     <= 1'b0;
         illegal_r    <= 1'b0;
         alu_opcode_r <= OP_NOP;
      end else begin
         state_r  <= state_s;
         ready_r  <= (state_s == ST_IDLE);
         halted_r <= (state_s == ST_HALT);
         if (accept_s) begin
            illegal_r    <= is_illegal(instr[31:27]);
            alu_opcode_r <= instr[31:27];
         end else begin
            illegal_r    <= 1'b0;
            alu_opcode_r <= OP_NOP;
         end
      end
   end

   // Datapath state: instruction latch, register-file write, flags and pc.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ir_r    <= 32'd0;
         flags_r <= 4'd0;
         pc_r    <= PC_ZERO;
         for (int i = 0; i < 8; i++) begin
            regs_r[i] <= DATA_ZERO;
         end
      end else begin
         if (accept_s) begin
            ir_r <= instr;
         end else begin
            ir_r <= ir_r;
         end
         if (state_r == ST_EXEC) begin
            pc_r <= pc_s;
            if (flags_we_s) begin
               flags_r <= {alu_C, alu_S, alu_O, alu_Z};
            end else begin
               flags_r <= flags_r;
            end
            if (wr_en_s && (rd_s != 3'd0)) begin
               regs_r[rd_s] <= wr_data_s;
            end else begin
               regs_r[rd_s] <= regs_r[rd_s];
            end
         end else begin
            pc_r <= pc_r;
         end
      end
   end

endmodule

// File: tb/tb_exec_control.sv
// Scoreboard bench for exec_control with a behavioural ALU in the loop.
module tb_exec_control;

   localparam logic [4:0] OP_NOP = 5'd0;
   localparam logic [4:0] OP_NOT = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_NEG = 5'd5;
   localparam logic [4:0] OP_ADD = 5'd6;
   localparam logic [4:0] OP_SUB = 5'd7;
   localparam logic [4:0] OP_MUL = 5'd8;
   localparam logic [4:0] OP_LD  = 5'd11;
   localparam logic [4:0] OP_JMP = 5'd13;
   localparam logic [4:0] OP_JC  = 5'd14;
   localparam logic [4:0] OP_JS  = 5'd15;
   localparam logic [4:0] OP_JO  = 5'd16;
   localparam logic [4:0] OP_JZ  = 5'd17;
   localparam logic [4:0] OP_HLT = 5'd18;

   logic        clk;
   logic        reset_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  alu_opcode;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_resultado;
   logic        alu_C, alu_S, alu_O, alu_Z;
   logic [3:0]  flags;
   logic [7:0]  pc;
   logic        halted;
   logic        illegal;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   typedef struct {
      logic [4:0]  op;
      logic        ill;
      logic [2:0]  rd;
      logic [31:0] val;
      logic [7:0]  pc;
      logic [3:0]  fl;
      logic        hlt;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          acc_cyc  = 0;
   int          prev_acc = 0;
   logic        mon_en   = 1'b0;
   logic [2:0]  idle_dbg = 3'd0;
   logic [32:0] sum33;

   exec_control #(.BITS_DATA(32), .BITS_PC(8)) dut (
      .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_resultado(alu_resultado), .alu_C(alu_C), .alu_S(alu_S), .alu_O(alu_O),
      .alu_Z(alu_Z), .flags(flags), .pc(pc), .halted(halted), .illegal(illegal),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU; unsupported opcodes return junk so leakage into state is visible.
   always_comb begin
      sum33         = 33'd0;
      alu_resultado = 32'hDEADBEEF;
      alu_C = 1'b1; alu_S = 1'b1; alu_O = 1'b1; alu_Z = 1'b1;
      case (alu_opcode)
         OP_NOT, OP_AND, OP_OR, OP_NEG: begin
            if (alu_opcode == OP_NOT)      alu_resultado = ~alu_a;
            else if (alu_opcode == OP_AND) alu_resultado = alu_a & alu_b;
            else if (alu_opcode == OP_OR)  alu_resultado = alu_a | alu_b;
            else                           alu_resultado = 32'd0 - alu_a;
            alu_C = (alu_opcode == OP_NEG) ? (alu_a != 32'd0) : 1'b0;
            alu_O = (alu_opcode == OP_NEG) ? (alu_a == 32'h80000000) : 1'b0;
            alu_S = alu_resultado[31];
            alu_Z = (alu_resultado == 32'd0);
         end
         OP_ADD: begin
            sum33 = {1'b0, alu_a} + {1'b0, alu_b};
            alu_resultado = sum33[31:0];
            alu_C = sum33[32];
            alu_O = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
            alu_S = sum33[31];
            alu_Z = (sum33[31:0] == 32'd0);
         end
         OP_SUB: begin
            sum33 = {1'b0, alu_a} - {1'b0, alu_b};
            alu_resultado = sum33[31:0];
            alu_C = sum33[32];
            alu_O = (alu_a[31] != alu_b[31]) && (sum33[31] != alu_a[31]);
            alu_S = sum33[31];
            alu_Z = (sum33[31:0] == 32'd0);
         end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [17:0] imm);
      return {op, rd, ra, rb, imm};
   endfunction

   // Push the expected writeback, then present the word until it is accepted.
   task automatic send(input logic [31:0] w, input logic [2:0] rd, input logic [31:0] val,
                       input logic [7:0] epc, input logic [3:0] efl, input logic ill);
      exp_t e;
      int   k;
      e.op = w[31:27]; e.ill = ill; e.rd = rd; e.val = val;
      e.pc = epc; e.fl = efl; e.hlt = (w[31:27] == OP_HLT);
      sb.push_back(e);
      @(negedge clk);
      instr       = w;
      instr_valid = 1'b1;
      k = 0;
      while (!instr_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (instr_ready) begin
         @(posedge clk);
         prev_acc = acc_cyc;
         acc_cyc  = cyc;
      end else begin
         check("accept_timeout", 32'd0, 32'd1);
      end
      #1 instr_valid = 1'b0;
   endtask

   // Monitor: on every EXEC cycle pop one expectation and compare the writeback.
   initial begin
      exp_t e;
      dbg_addr = 3'd0;
      forever begin
         @(negedge clk);
         if (mon_en && instr_ready === 1'b0 && halted === 1'b0) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               dbg_addr = e.rd;
               check("exec_opcode",  {27'd0, alu_opcode}, {27'd0, e.op});
               check("exec_illegal", {31'd0, illegal},    {31'd0, e.ill});
               @(negedge clk);
               #1;
               check("wb_pc",      {24'd0, pc},          {24'd0, e.pc});
               check("wb_flags",   {28'd0, flags},       {28'd0, e.fl});
               check("wb_reg",     dbg_data,             e.val);
               check("wb_halted",  {31'd0, halted},      {31'd0, e.hlt});
               check("wb_ready",   {31'd0, instr_ready}, {31'd0, ~e.hlt});
               check("wb_illegal", {31'd0, illegal},     32'd0);
               check("wb_opcode",  {27'd0, alu_opcode},  {27'd0, OP_NOP});
            end
         end else begin
            dbg_addr = idle_dbg;
         end
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      logic [31:0] dbl;
      int          k;
      reset_n = 1'b0; instr = 32'd0; instr_valid = 1'b0; idle_dbg = 3'd1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_ready",   {31'd0, instr_ready}, 32'd1);
      check("rst_halted",  {31'd0, halted},      32'd0);
      check("rst_illegal", {31'd0, illegal},     32'd0);
      check("rst_pc",      {24'd0, pc},          32'd0);
      check("rst_flags",   {28'd0, flags},       32'd0);
      check("rst_opcode",  {27'd0, alu_opcode},  {27'd0, OP_NOP});
      check("rst_r1",      dbg_data,             32'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Basic load/add and two-cycle cadence.
      send(mk(OP_LD,  3'd1, 3'd0, 3'd0, 18'd5), 3'd1, 32'd5, 8'd1, 4'b0000, 1'b0);
      send(mk(OP_LD,  3'd2, 3'd0, 3'd0, 18'd3), 3'd2, 32'd3, 8'd2, 4'b0000, 1'b0);
      send(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 18'd0), 3'd3, 32'd8, 8'd3, 4'b0000, 1'b0);
      check("issue_interval", acc_cyc - prev_acc, 32'd2);

      // NOT of a full 18-bit immediate.
      send(mk(OP_LD,  3'd1, 3'd0, 3'd0, 18'h3FFFF), 3'd1, 32'h0003FFFF, 8'd4, 4'b0000, 1'b0);
      send(mk(OP_NOT, 3'd2, 3'd1, 3'd0, 18'd0),     3'd2, 32'hFFFC0000, 8'd5, 4'b0100, 1'b0);

      // Build 0x7FFFFFFF by doubling then adding 0x1FFF.
      dbl = 32'h0003FFFF;
      for (int i = 0; i < 13; i++) begin
         dbl = dbl << 1;
         send(mk(OP_ADD, 3'd1, 3'd1, 3'd1, 18'd0), 3'd1, dbl, 8'(6 + i), 4'b0000, 1'b0);
      end
      send(mk(OP_LD,  3'd2, 3'd0, 3'd0, 18'h01FFF), 3'd2, 32'h00001FFF, 8'd19, 4'b0000, 1'b0);
      send(mk(OP_ADD, 3'd1, 3'd1, 3'd2, 18'd0), 3'd1, 32'h7FFFFFFF, 8'd20, 4'b0000, 1'b0);
      send(mk(OP_ADD, 3'd2, 3'd1, 3'd0, 18'd0), 3'd2, 32'h7FFFFFFF, 8'd21, 4'b0000, 1'b0);
      send(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 18'd0), 3'd3, 32'hFFFFFFFE, 8'd22, 4'b0110, 1'b0);
      send(mk(OP_JO,  3'd3, 3'd0, 3'd0, 18'h040), 3'd3, 32'hFFFFFFFE, 8'h40, 4'b0110, 1'b0);
      send(mk(OP_JZ,  3'd3, 3'd0, 3'd0, 18'h010), 3'd3, 32'hFFFFFFFE, 8'h41, 4'b0110, 1'b0);

      // Zero result, taken JZ, write to R0 discarded.
      send(mk(OP_SUB, 3'd3, 3'd1, 3'd1, 18'd0),   3'd3, 32'd0, 8'h42, 4'b0001, 1'b0);
      send(mk(OP_JZ,  3'd0, 3'd0, 3'd0, 18'h020), 3'd3, 32'd0, 8'h20, 4'b0001, 1'b0);
      send(mk(OP_LD,  3'd0, 3'd0, 3'd0, 18'h123), 3'd0, 32'd0, 8'h21, 4'b0001, 1'b0);
      send(mk(OP_JS,  3'd0, 3'd0, 3'd0, 18'h080), 3'd1, 32'h7FFFFFFF, 8'h22, 4'b0001, 1'b0);

      // Carry, taken JC, JMP and pc wrap.
      send(mk(OP_NOT, 3'd5, 3'd0, 3'd0, 18'd0), 3'd5, 32'hFFFFFFFF, 8'h23, 4'b0100, 1'b0);
      send(mk(OP_ADD, 3'd6, 3'd5, 3'd5, 18'd0), 3'd6, 32'hFFFFFFFE, 8'h24, 4'b1100, 1'b0);
      send(mk(OP_JC,  3'd0, 3'd0, 3'd0, 18'h030), 3'd6, 32'hFFFFFFFE, 8'h30, 4'b1100, 1'b0);
      send(mk(OP_JMP, 3'd0, 3'd0, 3'd0, 18'h0FF), 3'd6, 32'hFFFFFFFE, 8'hFF, 4'b1100, 1'b0);
      send(mk(OP_NOP, 3'd0, 3'd0, 3'd0, 18'd0),   3'd6, 32'hFFFFFFFE, 8'h00, 4'b1100, 1'b0);

      // Unsupported opcode, then halt.
      send(mk(OP_MUL, 3'd7, 3'd1, 3'd2, 18'd0), 3'd7, 32'd0, 8'h01, 4'b1100, 1'b1);
      send(mk(OP_HLT, 3'd7, 3'd0, 3'd0, 18'd0), 3'd7, 32'd0, 8'h01, 4'b1100, 1'b0);
      repeat (2) @(negedge clk);
      idle_dbg    = 3'd7;
      instr       = mk(OP_LD, 3'd7, 3'd0, 3'd0, 18'h055);
      instr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check("halt_halted", {31'd0, halted},      32'd1);
         check("halt_ready",  {31'd0, instr_ready}, 32'd0);
         check("halt_pc",     {24'd0, pc},          32'd1);
      end
      check("halt_r7", dbg_data, 32'd0);
      instr_valid = 1'b0;

      // Reset leaves HALT; reset during EXEC discards the ADD.
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      send(mk(OP_LD,  3'd1, 3'd0, 3'd0, 18'd7), 3'd1, 32'd7, 8'd1, 4'b0000, 1'b0);
      send(mk(OP_LD,  3'd2, 3'd0, 3'd0, 18'd9), 3'd2, 32'd9, 8'd2, 4'b0000, 1'b0);
      send(mk(OP_ADD, 3'd4, 3'd1, 3'd2, 18'd0), 3'd4, 32'd0, 8'd0, 4'b0000, 1'b0);
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Idle with valid low changes nothing.
      idle_dbg = 3'd1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         check("idle_ready", {31'd0, instr_ready}, 32'd1);
         check("idle_pc",    {24'd0, pc},          32'd0);
         check("idle_flags", {28'd0, flags},       32'd0);
         check("idle_r1",    dbg_data,             32'd0);
      end
      send(mk(OP_LD, 3'd1, 3'd0, 3'd0, 18'h02A), 3'd1, 32'h0000002A, 8'd1, 4'b0000, 1'b0);

      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      check("sb_drain", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_control.md
# exec_control

Multi-cycle issue and writeback controller that sits directly upstream of the combinational ALU. It accepts 32-bit instructions over a valid/ready handshake and reads two source operands from an internal register file. It drives the ALU opcode and operand buses, then writes the ALU result and the C/S/O/Z flags back. It also owns the program counter, conditional jumps on the stored flags, load-immediate, and halt.

## Interface
Parameters:
- BITS_DATA, 32: data width; must match the ALU.
- BITS_PC, 8: program counter width.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- instr  input  32  instruction word: [31:27] opcode, [26:24] rd, [23:21] ra, [20:18] rb, [17:0] imm.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block accepts an instruction this cycle.
- alu_opcode  output  5  opcode presented to the ALU.
- alu_a  output  BITS_DATA  first ALU operand, R[ra].
- alu_b  output  BITS_DATA  second ALU operand, R[rb].
- alu_resultado  input  BITS_DATA  ALU result.
- alu_C, alu_S, alu_O, alu_Z  input  1 each  ALU flags.
- flags  output  4  stored {C,S,O,Z}.
- pc  output  BITS_PC  program counter.
- halted  output  1  block is in HALT.
- illegal  output  1  one-cycle pulse for an unsupported opcode.
- dbg_addr  input  3  register-file debug read address.
- dbg_data  output  BITS_DATA  combinational R[dbg_addr].

## Operation
- Register file: 8 × BITS_DATA. R0 always reads 0, and writes to R0 are discarded. Two combinational read ports, one write port.
- States:
  - IDLE: instr_ready=1. On instr_valid=1, latch instr into ir and go to EXEC.
  - EXEC: instr_ready=0. Executes ir and returns to IDLE, except HLT, which goes to HALT.
  - HALT: instr_ready=0, halted=1. Terminal; only reset leaves it.
- alu_opcode equals ir[31:27] in EXEC. It is `OP_NOP in every other state.
- alu_a and alu_b always show R[ir.ra] and R[ir.rb].
- Per opcode, all applied on the edge leaving EXEC:
  - ALU ops (`OP_NOT, `OP_AND, `OP_OR, `OP_NEG, `OP_ADD, `OP_SUB): R[rd] <= alu_resultado; flags <= {alu_C,alu_S,alu_O,alu_Z}; pc <= pc+1.
  - `OP_LD: load-immediate, R[rd] <= zero-extended imm; flags unchanged; pc+1.
  - `OP_JMP: pc <= imm[BITS_PC-1:0].
  - `OP_JC / `OP_JS / `OP_JO / `OP_JZ: if flags C / S / O / Z is 1, pc <= imm[BITS_PC-1:0]; otherwise pc+1.
  - `OP_NOP: pc+1 only.
  - `OP_HLT: pc unchanged; go to HALT.
  - Any other opcode (`OP_STR, `OP_XOR, `OP_MUL, `OP_DIV, `OP_MOD, undefined): treated as NOP; illegal=1 during EXEC.
- ALU outputs are sampled only for the six ALU ops, so X values the ALU produces for other opcodes never reach state.
- Flags are written even when rd=0.
- pc wraps modulo 2^BITS_PC.

## Timing
- Reset (reset_n=0 at a clk edge) sets:
  - state IDLE, all registers 0, flags 0, pc 0, ir 0;
  - instr_ready=1 after the edge; halted=0, illegal=0.
- Reset wins over every other event, including mid-EXEC and in HALT. An instruction in EXEC is discarded with no register, flag or pc update.
- Latency is 2 cycles per instruction: the accept edge, then the EXEC edge. Peak throughput is one instruction per 2 cycles.
- Handshake:
  - Transfer happens on an edge where instr_valid && instr_ready.
  - The producer holds instr stable while valid && !ready.
  - instr_valid in EXEC or HALT is ignored and is not queued.
- instr_ready is a function of state only, with no combinational path from instr_valid.
- A register written in EXEC is visible on alu_a, alu_b and dbg_data in the very next cycle, so there is no hazard for back-to-back dependent instructions.
- A conditional jump uses the flags as stored before its own EXEC edge.

## Test plan
- Reset, then LD R1 ← 5, LD R2 ← 3, ADD R3=R1+R2 → dbg R3=8; flags=0000; pc=3; each instruction takes 2 cycles.
- LD R1 ← 0x3FFFF, NOT R2=R1 → R2=0xFFFC0000; flags S=1, Z=0, C=0, O=0.
- ADD overflow, with R1=R2=0x7FFFFFFF built from LD plus adds → result 0xFFFFFFFE, O=1, S=1; then JO 0x40 → pc=0x40; then JZ 0x10 → pc=0x41.
- SUB R3=R1−R1, then JZ 0x20 → Z=1 and pc=0x20. A write to R0 leaves dbg R0=0.
- Opcode `OP_MUL → illegal pulses exactly 1 cycle, no register change, pc+1. Then HLT → halted=1, instr_ready=0, and later valid instructions are ignored for 10 cycles.
- Assert reset_n=0 during an EXEC of ADD R4 → R4 stays 0, pc=0, state IDLE with instr_ready=1 after the edge. Holding instr_valid low in IDLE for N cycles changes nothing.
